data_memory_responder: RTL and testbench

Word-organised data memory that services the core's load/store requests over a valid/ready request channel and a valid/ready response channel. It sits on the data side of the processor, answering the datapath's address (ALU result), store data and write strobe. It models a configurable number of wait states and flags misaligned or out-of-range accesses instead of corrupting memory. One transaction is outstanding at a time.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_word_ram.sv | 37 +++
 rtl/data_memory_responder.sv | 142 ++++++++++++++
 tb/tb_data_memory_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam int WAIT_CNT_W = 4;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

    // off is (addr - base); with an aligned base its low bits equal the address low bits.
    function automatic logic access_error(input logic [31:0] off, input int unsigned depth);
        return (off[1:0] != 2'b00) || ({2'b00, off[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/dmem_word_ram.sv
// rtl/dmem_word_ram.sv - word array with byte write enables and a registered read port
module dmem_word_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic          re,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read data only moves on a read strobe so the response stays stable while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - load/store responder with wait states and access error flagging
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(1);

    dmem_state_e           state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q;
    logic                  write_q;
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;
    logic                  err_q;
    logic                  ready_q;

    logic                  req_fire;
    logic                  access;
    logic                  acc_write;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic [31:0]           acc_off;
    logic [3:0]            acc_be;
    logic                  acc_err;
    logic                  ram_we;
    logic                  ram_re;
    logic [31:0]           ram_rdata;

    // ready_q is only ever set while the next state is IDLE.
    assign req_fire = req_valid && ready_q;

    // With zero wait states the access happens on the accept edge, straight from the request bus.
    always_comb begin
        acc_write = write_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_be    = be_q;
        if (state_q == IDLE) begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end
        acc_off = acc_addr - BASE_ADDR;
        acc_err = access_error(acc_off, DEPTH_WORDS);
        access  = 1'b0;
        if (state_q == IDLE) begin
            access = req_fire && (WAIT_STATES == 0);
        end else if (state_q == WAIT) begin
            access = (cnt_q == WAIT_LAST);
        end
        ram_we = access && acc_write && !acc_err;
        ram_re = access && !acc_write && !acc_err;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_fire) begin
                    state_d = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
            if (state_q == IDLE && req_fire) begin
                cnt_q   <= WAIT_LOAD;
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
                err_q   <= acc_err;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - WAIT_LAST;
            end
        end
    end

    dmem_word_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk  (clk),
        .reset(reset),
        .we   (ram_we),
        .be   (acc_be),
        .addr (acc_off[AW+1:2]),
        .wdata(acc_wdata),
        .re   (ram_re),
        .rdata(ram_rdata)
    );

    assign req_ready = ready_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_error = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !write_q && !err_q) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - randomized scoreboard bench for data_memory_responder
module tb_data_memory_responder;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 1024;
    localparam int          WS    = 2;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        exp_q[$];
    logic [31:0] model_mem [DEPTH];
    int          force_low = 0;
    bit          rand_bp = 0;

    data_memory_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE),
        .WAIT_STATES(WS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_be   (req_be),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_err(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a % 4 != 0) || (off >= 32'(DEPTH * 4));
    endfunction

    // Drives one request starting just after a rising edge; returns just after its accept edge.
    task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input bit track);
        exp_t e;
        int   idx;
        bit   got;
        e.err   = model_err(a);
        e.rdata = 32'h0;
        idx     = int'((a - BASE) / 4);
        if (track) begin
            if (!e.err && !wr) e.rdata = model_mem[idx];
            if (!e.err && wr) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
            end
            exp_q.push_back(e);
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("req_accept_timeout", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (force_low > 0) begin
                rsp_ready = 1'b0;
                if (rsp_valid) force_low--;
            end else begin
                rsp_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    initial begin : monitor
        bit          hs_pend = 0;
        int          lat = 0;
        bit          rsp_open = 0;
        bit          post_rsp = 0;
        exp_t        cur;
        logic [31:0] held_d = '0;
        logic        held_e = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                hs_pend  = 0;
                rsp_open = 0;
                post_rsp = 0;
            end else begin
                if (post_rsp) begin
                    chk("rsp_valid_clear", 32'(rsp_valid), 32'd0);
                    chk("req_ready_after_rsp", 32'(req_ready), 32'd1);
                    post_rsp = 0;
                end
                if (hs_pend) begin
                    lat++;
                    if (!rsp_valid) chk("req_ready_wait", 32'(req_ready), 32'd0);
                end
                if (rsp_valid) begin
                    if (!rsp_open) begin
                        rsp_open = 1;
                        chk("rsp_latency", 32'(lat), 32'(WS + 1));
                        hs_pend = 0;
                        if (exp_q.size() == 0) begin
                            chk("unexpected_rsp", 32'd1, 32'd0);
                            cur.err   = 1'bx;
                            cur.rdata = 'x;
                        end else begin
                            cur = exp_q.pop_front();
                        end
                    end else begin
                        chk("rsp_rdata_stable", rsp_rdata, held_d);
                        chk("rsp_error_stable", 32'(rsp_error), 32'(held_e));
                    end
                    chk("req_ready_resp", 32'(req_ready), 32'd0);
                    held_d = rsp_rdata;
                    held_e = rsp_error;
                    if (rsp_ready) begin
                        chk("rsp_rdata", rsp_rdata, cur.rdata);
                        chk("rsp_error", 32'(rsp_error), 32'(cur.err));
                        rsp_open = 0;
                        post_rsp = 1;
                    end
                end
                if (req_valid && req_ready) begin
                    hs_pend = 1;
                    lat     = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int          k;
        int          w;
        logic [31:0] a;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 'x;

        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_error", 32'(rsp_error), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        issue(1, 32'h1001_0004, 32'hDEAD_BEEF, 4'b1111, 1);
        issue(0, 32'h1001_0004, 32'h0, 4'b0000, 1);
        issue(1, 32'h1001_0004, 32'h0000_AA00, 4'b0010, 1);
        issue(0, 32'h1001_0004, 32'h0, 4'b1111, 1);
        issue(1, 32'h1001_0006, 32'h1234_5678, 4'b1111, 1);
        issue(0, 32'h1001_0004, 32'h0, 4'b0000, 1);
        issue(0, 32'h1001_1000, 32'h0, 4'b0000, 1);
        issue(0, 32'h1000_FFFC, 32'h0, 4'b0000, 1);
        issue(1, 32'h1001_0004, 32'hFFFF_FFFF, 4'b0000, 1);

        force_low = 5;
        issue(0, 32'h1001_0004, 32'h0, 4'b0000, 1);
        issue(0, 32'h1001_0004, 32'h0, 4'b0000, 1);

        issue(1, 32'h1001_0008, 32'hCAFE_F00D, 4'b1111, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_req_ready", 32'(req_ready), 32'd0);
        chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("postreset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("postreset_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        issue(0, 32'h1001_0004, 32'h0, 4'b0000, 1);
        issue(1, 32'h1001_0008, 32'h0, 4'b1111, 1);
        issue(0, 32'h1001_0008, 32'h0, 4'b0000, 1);

        rand_bp = 1;
        for (int i = 0; i < 16; i++) issue(1, BASE + 32'(4 * i), $urandom, 4'b1111, 1);
        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 9);
            w = $urandom_range(0, 15);
            if (k <= 3) begin
                issue(1, BASE + 32'(4 * w), $urandom, 4'($urandom_range(0, 15)), 1);
            end else if (k <= 7) begin
                issue(0, BASE + 32'(4 * w), $urandom, 4'($urandom_range(0, 15)), 1);
            end else if (k == 8) begin
                a = BASE + 32'(4 * w) + 32'($urandom_range(1, 3));
                issue(1'($urandom_range(0, 1)), a, $urandom, 4'b1111, 1);
            end else begin
                if ($urandom_range(0, 1) == 1) a = BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 100));
                else a = BASE - 32'(4 * $urandom_range(1, 100));
                issue(1'($urandom_range(0, 1)), a, $urandom, 4'b1111, 1);
            end
        end

        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rsp_valid) break;
        end
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
